// File: rtl/pwm_ctrl_pkg.sv
// Shared types and widths for the PWM fade sequencer.
package pwm_ctrl_pkg;

    localparam int DUTY_W    = 8;
    localparam int DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Interval counter: one-cycle tick every (div+1) enabled clocks.
module pwm_tick_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = (r_cnt == i_div);
    assign o_tick = i_en && w_hit && !i_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_hit ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Ramps the live PWM duty toward a latched target, one step per interval.
module pwm_fade_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [DUTY_W-1:0] step,
    input  logic [DIV_W-1:0]  tick_div,
    input  logic              start,
    input  logic              abort,
    output logic [DUTY_W-1:0] pwm_duty_cycle,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] r_tgt;
    logic [DUTY_W-1:0] r_step;
    logic [DIV_W-1:0]  r_div;
    logic              w_load;
    logic              w_clr;
    logic              w_tick;
    logic              w_down;
    logic [DUTY_W:0]   w_diff;

    pwm_tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (r_state == ST_RAMP),
        .i_div  (r_div),
        .o_tick (w_tick)
    );

    // 9-bit distance so the final step clamps instead of wrapping
    assign w_down = (r_duty > r_tgt);
    assign w_diff = w_down ? ({1'b0, r_duty} - {1'b0, r_tgt})
                           : ({1'b0, r_tgt} - {1'b0, r_duty});

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_clr       = 1'b1;
        end else if (start) begin
            w_load = 1'b1;
            w_clr  = 1'b1;
            if (target_duty == r_duty) begin
                w_state_nxt = ST_DONE;
            end else if (step == '0) begin
                w_duty_nxt  = target_duty;
                w_state_nxt = ST_DONE;
            end else begin
                w_state_nxt = ST_RAMP;
            end
        end else begin
            unique case (r_state)
                ST_RAMP: begin
                    if (w_tick) begin
                        if (w_diff <= {1'b0, r_step}) begin
                            w_duty_nxt  = r_tgt;
                            w_state_nxt = ST_DONE;
                        end else if (w_down) begin
                            w_duty_nxt = r_duty - r_step;
                        end else begin
                            w_duty_nxt = r_duty + r_step;
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_step  <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            if (w_load) begin
                r_tgt  <= target_duty;
                r_step <= step;
                r_div  <= tick_div;
            end
        end
    end

    assign pwm_duty_cycle = r_duty;
    assign busy           = (r_state == ST_RAMP);
    assign done           = (r_state == ST_DONE);

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench: stimulus queues expected duty/done events, monitor checks them.
module tb_pwm_fade_sequencer;

    typedef struct {
        logic [7:0] duty;
        logic       done;
        logic       busy;
        int         cyc;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  target_duty;
    logic [7:0]  step;
    logic [15:0] tick_div;
    logic        start;
    logic        abort;
    logic [7:0]  pwm_duty_cycle;
    logic        busy;
    logic        done;

    ev_t  exp_q[$];
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   busy_total;
    int   done_total;
    bit   mon_en;
    logic [7:0] prev_duty;

    pwm_fade_sequencer #(.DIV_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .target_duty    (target_duty),
        .step           (step),
        .tick_div       (tick_div),
        .start          (start),
        .abort          (abort),
        .pwm_duty_cycle (pwm_duty_cycle),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: an output event is any duty change or a done pulse
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_total = busy_total + 1;
            if (done) done_total = done_total + 1;
            if (pwm_duty_cycle !== prev_duty || done === 1'b1) begin
                n_chk = n_chk + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_event cyc=%0d duty=%0d done=%b busy=%b",
                             cyc, pwm_duty_cycle, done, busy);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (pwm_duty_cycle !== e.duty || done !== e.done ||
                        busy !== e.busy || cyc != e.cyc) begin
                        n_fail = n_fail + 1;
                        $display("FAIL event got duty=%0d done=%b busy=%b cyc=%0d want duty=%0d done=%b busy=%b cyc=%0d",
                                 pwm_duty_cycle, done, busy, cyc,
                                 e.duty, e.done, e.busy, e.cyc);
                    end
                end
            end
        end
        prev_duty = pwm_duty_cycle;
    end

    task automatic push(input logic [7:0] d, input logic dn,
                        input logic b, input int c);
        ev_t e;
        e.duty = d;
        e.done = dn;
        e.busy = b;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_chk = n_chk + 1;
        if (act != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic pulse_start(input logic [7:0] t, input logic [7:0] s,
                               input logic [15:0] d);
        target_duty = t;
        step        = s;
        tick_div    = d;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        target_duty = 8'hA5;
        step        = 8'h01;
        tick_div    = 16'h0007;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    int t0;
    int b0;
    int d0;

    initial begin
        n_chk = 0;
        n_fail = 0;
        busy_total = 0;
        done_total = 0;
        mon_en = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        start = 1'b1;
        target_duty = 8'd77;
        step = 8'd0;
        tick_div = 16'd0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_duty", pwm_duty_cycle, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_duty", pwm_duty_cycle, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        mon_en = 1'b1;

        // Up-ramp 0 -> 10, step 3, every 3 clocks
        b0 = busy_total;
        d0 = done_total;
        t0 = cyc + 1;
        push(8'd3, 1'b0, 1'b1, t0 + 3);
        push(8'd6, 1'b0, 1'b1, t0 + 6);
        push(8'd9, 1'b0, 1'b1, t0 + 9);
        push(8'd10, 1'b1, 1'b0, t0 + 12);
        pulse_start(8'd10, 8'd3, 16'd2);
        drain("up_drain");
        check("up_busy_cycles", busy_total - b0, 12);
        check("up_done_pulses", done_total - d0, 1);

        // Jump to 5, then down to 0 with an oversized step
        t0 = cyc + 1;
        push(8'd5, 1'b1, 1'b0, t0);
        pulse_start(8'd5, 8'd0, 16'd0);
        drain("to5_drain");
        d0 = done_total;
        t0 = cyc + 1;
        push(8'd0, 1'b1, 1'b0, t0 + 1);
        pulse_start(8'd0, 8'd200, 16'd0);
        drain("down_drain");
        check("down_duty", pwm_duty_cycle, 0);
        check("down_done_pulses", done_total - d0, 1);

        // Immediate jump with step 0
        b0 = busy_total;
        d0 = done_total;
        t0 = cyc + 1;
        push(8'd128, 1'b1, 1'b0, t0);
        pulse_start(8'd128, 8'd0, 16'd5);
        drain("jump_drain");
        check("jump_busy_cycles", busy_total - b0, 0);
        check("jump_done_pulses", done_total - d0, 1);

        // Target equals current duty
        b0 = busy_total;
        t0 = cyc + 1;
        push(8'd128, 1'b1, 1'b0, t0);
        pulse_start(8'd128, 8'd7, 16'd3);
        drain("equal_drain");
        check("equal_duty", pwm_duty_cycle, 128);
        check("equal_busy_cycles", busy_total - b0, 0);

        // Retarget mid-ramp: 0 -> 200 reaches 50, then new target 20
        t0 = cyc + 1;
        push(8'd0, 1'b1, 1'b0, t0);
        pulse_start(8'd0, 8'd0, 16'd0);
        drain("zero_drain");
        d0 = done_total;
        t0 = cyc + 1;
        push(8'd50, 1'b0, 1'b1, t0 + 5);
        pulse_start(8'd200, 8'd50, 16'd4);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("retgt_mid_duty", pwm_duty_cycle, 50);
        check("retgt_mid_busy", busy, 1);
        t0 = cyc + 1;
        push(8'd40, 1'b0, 1'b1, t0 + 1);
        push(8'd30, 1'b0, 1'b1, t0 + 2);
        push(8'd20, 1'b1, 1'b0, t0 + 3);
        pulse_start(8'd20, 8'd10, 16'd0);
        drain("retgt_drain");
        check("retgt_done_pulses", done_total - d0, 1);

        // Abort together with start while ramping through 30
        t0 = cyc + 1;
        push(8'd30, 1'b0, 1'b1, t0 + 1);
        pulse_start(8'd60, 8'd10, 16'd0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        target_duty = 8'd99;
        step = 8'd0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_duty", pwm_duty_cycle, 30);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort_hold_duty", pwm_duty_cycle, 30);
        check("abort_hold_busy", busy, 0);
        check("abort_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

- Controller that sequences the duty-cycle input of the PWM peripheral.
- Register values latched by the SPI peripheral (target duty, step, step interval) are not applied at once. The block ramps the live duty cycle toward the target by a fixed step, once every programmable number of clocks.
- It sits between the SPI register outputs and the `pwm_duty_cycle` input of `pwm_peripheral`.
- It reports busy and a one-cycle done pulse for status readback.

## Interface

Parameters:
- `DIV_W`, default 16, width of the step-interval divider.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `target_duty` in 8: requested final duty cycle; sampled only on `start`.
- `step` in 8: duty increment per update; sampled on `start`; 0 means jump immediately.
- `tick_div` in DIV_W: clocks per update minus 1; sampled on `start`.
- `start` in 1: single-cycle request to begin or retarget a ramp.
- `abort` in 1: freeze the duty at its current value and go idle.
- `pwm_duty_cycle` out 8: live duty cycle, drives `pwm_peripheral`.
- `busy` out 1: high while in RAMP.
- `done` out 1: one-cycle pulse when the duty reaches the target.

## Operation

- States:
  - IDLE: hold the duty.
  - RAMP: count and step.
  - DONE: one cycle, `done`=1.
- Latched registers: `tgt_q`, `step_q`, `div_q`, and the interval counter `cnt` (DIV_W bits).
- `start` accepted in any state:
  - Latches `tgt_q`, `step_q`, `div_q` and clears `cnt`.
  - If `target_duty` equals the current duty, go to DONE.
  - Else if `step` is 0, set duty to `target_duty` and go to DONE.
  - Otherwise go to RAMP.
- RAMP, each clock:
  - If `cnt != div_q`, then `cnt` increments.
  - Otherwise `cnt` is set to 0 and the duty updates.
- Duty update:
  - Compute `diff = |tgt_q - duty|` at 9-bit width.
  - If `diff <= step_q`, then duty is set to `tgt_q` and the state goes to DONE.
  - Otherwise the duty moves by `step_q` toward `tgt_q`.
  - The duty never overshoots the target and never wraps past 0 or 255.
- DONE goes to IDLE next clock, unless `start` is asserted that cycle, in which case `start` is handled as above.
- `abort` sends any state to IDLE. The duty holds and `cnt` clears.
- `target_duty`, `step` and `tick_div` changing outside a `start` cycle has no effect.

## Timing

- Reset (`rst_n`=0 at an edge) sets:
  - `pwm_duty_cycle` = 0, `busy` = 0, `done` = 0.
  - State IDLE; `cnt`, `tgt_q`, `step_q`, `div_q` all 0.
- Reset mid-ramp wins over everything, including `start` and `abort`.
- Ramp latency:
  - `start` is sampled at edge t.
  - The first duty change is visible after edge t+div_q+1.
  - After that the period is div_q+1 clocks.
  - With `tick_div`=0, the duty changes on every edge.
- Immediate cases (equal target, or `step`=0):
  - After edge t, `done`=1 and `busy`=0, for exactly one cycle.
  - The new duty is visible after that same edge.
- End of ramp: `busy` falls and `done` rises on the same edge as the final duty update.
- `busy` is registered: high from the edge after an accepted `start` until the final update.
- Simultaneous `start` and `abort`: `abort` wins and `start` is dropped.
- `start` during RAMP (retarget):
  - The ramp restarts from the current duty with the new parameters.
  - `cnt` clears and no `done` is generated for the old ramp.

## Structure

- Package `pwm_ctrl_pkg`:
  - State enum (IDLE, RAMP, DONE).
  - `DUTY_W`=8.
  - Default `DIV_W`.
- Sub-module `pwm_tick_prescaler`:
  - Contents: `cnt`, clear input, `div` input, one-cycle `tick` output.
  - Instantiated once.
- The FSM and saturating step arithmetic stay in the top of this block.

## Test plan

- Reset:
  - Stimulus: hold `rst_n`=0 for 2 clocks while `start`=1.
  - Required: duty=0, `busy`=0, `done`=0 throughout and one cycle after release.
- Up-ramp:
  - Stimulus: from duty 0, `start` with target=10, step=3, `tick_div`=2.
  - Required: duty goes 3, 6, 9, 10, with changes every 3 clocks, the first 3 clocks after `start`.
  - Required: `done` pulses once with the final update; `busy` is high for 12 cycles.
- Down-ramp near the rail:
  - Stimulus: from duty 5, target=0, step=200, `tick_div`=0.
  - Required: duty=0 one clock after `start`, no wrap; `done` pulses.
- Immediate cases:
  - Stimulus: step=0 with target=128.
  - Required: duty=128 after one edge, `done` for exactly 1 cycle, `busy` never high.
  - Stimulus: target equal to the current duty.
  - Required: `done` only, duty unchanged.
- Retarget and abort:
  - Stimulus: mid-ramp (duty=50, heading to 200), `start` with target=20, step=10, `tick_div`=0.
  - Required: duty goes 40, 30, 20, with no `done` for the old ramp.
  - Stimulus: `abort` at duty 30 together with `start`.
  - Required: IDLE and duty holds at 30.
